// File: rtl/prog_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prog_loader_if : byte-stream input and instruction-RAM write port  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface prog_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prog_loader : loads instruction RAM from a checksummed byte stream |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module prog_loader #(
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  prog_loader_if.slave     bus,
  output logic             hold,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  bcnt;
  logic [31:0] word;
  logic [31:0] n;
  logic [31:0] widx;
  logic [31:0] sum;
  logic [31:0] word_next;
  logic        accept;
  logic        last_byte;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_byte = (bcnt == 2'd3);

  // Each byte lands in the lane selected by the byte counter.
  always_comb begin
    word_next = word;
    word_next[{bcnt, 3'b000} +: 8] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_HDR;
      bcnt          <= 2'd0;
      word          <= 32'd0;
      n             <= 32'd0;
      widx          <= 32'd0;
      sum           <= 32'd0;
      bus.in_ready  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      hold          <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (accept) begin
        word <= word_next;
        bcnt <= bcnt + 2'd1;
        if (last_byte) begin
          case (state)
            S_HDR: begin
              n <= word_next;
              if (word_next == 32'd0) begin
                state <= S_CHK;
              end else if (word_next > 32'(DEPTH)) begin
                state        <= S_ERR;
                err          <= 1'b1;
                bus.in_ready <= 1'b0;
              end else begin
                state <= S_DATA;
              end
            end
            S_DATA: begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= widx;
              bus.mem_wdata <= word_next;
              sum           <= sum + word_next;
              widx          <= widx + 32'd1;
              if (widx == n - 32'd1) begin
                state <= S_CHK;
              end
            end
            S_CHK: begin
              bus.in_ready <= 1'b0;
              if (word_next == sum) begin
                state <= S_DONE;
                done  <= 1'b1;
                hold  <= 1'b0;
              end else begin
                state <= S_ERR;
                err   <= 1'b1;
              end
            end
            default: begin
              state <= state;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_prog_loader : directed self-checking bench for prog_loader      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_prog_loader;

  logic clk;
  logic rst;
  logic hold;
  logic done;
  logic err;
  int   passed;
  int   total;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  prog_loader_if bus ();

  prog_loader #(.DEPTH(1024)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .hold (hold),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe half a cycle after it is registered.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      log_addr.push_back(bus.mem_addr);
      log_data.push_back(bus.mem_wdata);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[k*8 +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); else passed++;
    total++; if (bus.mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else passed++;
    total++; if (bus.mem_wdata !== 32'd0) $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); else passed++;
    total++; if (hold !== 1'b1) $display("FAIL reset_hold: got %b want 1", hold); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
  endtask

  task automatic check_two_writes(input string tag, input logic [31:0] d0, input logic [31:0] d1);
    total++;
    if (log_addr.size() != 2) begin
      $display("FAIL %s_write_count: got %0d want 2", tag, log_addr.size());
    end else begin
      passed++;
      total++; if (log_addr[0] !== 32'd0 || log_data[0] !== d0)
        $display("FAIL %s_write0: got addr %h data %h want addr 0 data %h", tag, log_addr[0], log_data[0], d0);
      else passed++;
      total++; if (log_addr[1] !== 32'd1 || log_data[1] !== d1)
        $display("FAIL %s_write1: got addr %h data %h want addr 1 data %h", tag, log_addr[1], log_data[1], d1);
      else passed++;
    end
  endtask

  task automatic test_good_image();
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h0010_0013, 0);
    send_word(32'h0020_0093, 0);
    send_byte(8'hA6, 0);
    send_byte(8'h00, 0);
    send_byte(8'h30, 0);
    total++; if (done !== 1'b0 || hold !== 1'b1) $display("FAIL good_early_done: got done %b hold %b want 0 1", done, hold); else passed++;
    send_byte(8'h00, 0);
    check_two_writes("good", 32'h0010_0013, 32'h0020_0093);
    total++; if (done !== 1'b1) $display("FAIL good_done: got %b want 1", done); else passed++;
    total++; if (hold !== 1'b0) $display("FAIL good_hold: got %b want 0", hold); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL good_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (err !== 1'b0) $display("FAIL good_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h0010_0013, 0);
    send_word(32'h0020_0093, 0);
    send_word(32'h0000_0000, 0);
    check_two_writes("badsum", 32'h0010_0013, 32'h0020_0093);
    total++; if (err !== 1'b1) $display("FAIL badsum_err: got %b want 1", err); else passed++;
    total++; if (done !== 1'b0) $display("FAIL badsum_done: got %b want 0", done); else passed++;
    total++; if (hold !== 1'b1) $display("FAIL badsum_hold: got %b want 1", hold); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL badsum_in_ready: got %b want 0", bus.in_ready); else passed++;
  endtask

  task automatic test_too_long();
    do_reset();
    send_word(32'h0000_0401, 0);
    total++; if (err !== 1'b1) $display("FAIL toolong_err: got %b want 1", err); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL toolong_in_ready: got %b want 0", bus.in_ready); else passed++;
    send_word(32'h1122_3344, 0);
    send_word(32'h5566_7788, 0);
    total++; if (log_addr.size() != 0) $display("FAIL toolong_writes: got %0d want 0", log_addr.size()); else passed++;
    total++; if (done !== 1'b0 || err !== 1'b1) $display("FAIL toolong_sticky: got done %b err %b want 0 1", done, err); else passed++;
  endtask

  task automatic test_n_zero();
    do_reset();
    send_word(32'd0, 0);
    total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL nzero_hdr: got done %b err %b want 0 0", done, err); else passed++;
    send_word(32'd0, 0);
    total++; if (done !== 1'b1) $display("FAIL nzero_done: got %b want 1", done); else passed++;
    total++; if (log_addr.size() != 0) $display("FAIL nzero_writes: got %0d want 0", log_addr.size()); else passed++;
  endtask

  task automatic test_gaps_carry();
    do_reset();
    send_word(32'd2, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_word(32'h0000_0002, 3);
    send_word(32'h0000_0001, 3);
    check_two_writes("carry", 32'hFFFF_FFFF, 32'h0000_0002);
    total++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL carry_done: got done %b err %b want 1 0", done, err); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h0010_0013, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    // Reset and a valid byte together: the reset must win.
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) $display("FAIL midrst_ctrl: got ready %b we %b want 1 0", bus.in_ready, bus.mem_we); else passed++;
    total++; if (bus.mem_wdata !== 32'd0 || bus.mem_addr !== 32'd0) $display("FAIL midrst_bus: got addr %h data %h want 0 0", bus.mem_addr, bus.mem_wdata); else passed++;
    total++; if (hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) $display("FAIL midrst_status: got hold %b done %b err %b want 1 0 0", hold, done, err); else passed++;
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
    send_word(32'd2, 0);
    send_word(32'h0010_0013, 0);
    send_word(32'h0020_0093, 0);
    send_word(32'h0030_00A6, 0);
    check_two_writes("replay", 32'h0010_0013, 32'h0020_0093);
    total++; if (done !== 1'b1) $display("FAIL replay_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_full_depth();
    do_reset();
    send_word(32'd1024, 0);
    for (int i = 0; i < 1024; i++) begin
      send_word(32'(i), 0);
    end
    // Sum of 0..1023 = 523776.
    send_word(32'h0007_FE00, 0);
    total++; if (log_addr.size() != 1024) $display("FAIL depth_count: got %0d want 1024", log_addr.size()); else passed++;
    total++; if (log_addr.size() == 1024 && (log_addr[1023] !== 32'd1023 || log_data[1023] !== 32'd1023))
      $display("FAIL depth_last: got addr %h data %h want 3ff 3ff", log_addr[1023], log_data[1023]);
    else if (log_addr.size() == 1024) passed++;
    total++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL depth_done: got done %b err %b want 1 0", done, err); else passed++;
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_too_long();
    test_n_zero();
    test_gaps_carry();
    test_reset_mid();
    test_full_depth();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
